// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that seeds a Fibonacci LFSR, steps it a programmed number of times and pulses done.
// Optional PERIOD_CHECK_EN adds period/period_valid: the step count at which the loaded seed first recurs.
module lfsr_seq_ctrl #(
  parameter int                WIDTH        = 4,
  parameter logic [WIDTH-1:0]  TAPS         = 4'b1100,
  parameter int                CNT_W        = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = 4'b0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] step_count,
  input  logic             hold,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_flag,
  output logic             done,
  output logic             lockup_err
`ifdef PERIOD_CHECK_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] eff_seed;

  assign stepped  = lfsr_next(data_out);
  // An all-zero state would lock the LFSR, so it is replaced before loading.
  assign eff_seed = (seed_q == '0) ? DEFAULT_SEED : seed_q;

`ifdef PERIOD_CHECK_EN
  logic [WIDTH-1:0] loaded;
  logic [CNT_W-1:0] steps;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      seed_q     <= '0;
      remaining  <= '0;
      data_out   <= '0;
      valid_flag <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      lockup_err <= 1'b0;
`ifdef PERIOD_CHECK_EN
      loaded       <= '0;
      steps        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
`endif
    end else begin
      valid_flag <= 1'b0;
      done       <= 1'b0;
      lockup_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_q    <= seed;
            remaining <= step_count;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          data_out   <= eff_seed;
          lockup_err <= (seed_q == '0);
          state      <= (remaining == '0) ? DONE : RUN;
`ifdef PERIOD_CHECK_EN
          loaded       <= eff_seed;
          steps        <= '0;
          period       <= '0;
          period_valid <= 1'b0;
`endif
        end
        RUN: begin
          if (!hold) begin
            data_out   <= stepped;
            valid_flag <= 1'b1;
            remaining  <= remaining - 1'b1;
            if (remaining == 1) state <= DONE;
`ifdef PERIOD_CHECK_EN
            steps <= steps + 1'b1;
            if (!period_valid && stepped == loaded) begin
              period       <= steps + 1'b1;
              period_valid <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: expected words are queued at start and popped on valid_flag.
// Define PERIOD_CHECK_EN for both files to exercise the period detector.
module tb_lfsr_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] seed;
  logic [7:0] step_count;
  logic       hold;
  logic       busy;
  logic [3:0] data_out;
  logic       valid_flag;
  logic       done;
  logic       lockup_err;
`ifdef PERIOD_CHECK_EN
  logic [7:0] period;
  logic       period_valid;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  lfsr_seq_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .step_count (step_count),
    .hold       (hold),
    .busy       (busy),
    .data_out   (data_out),
    .valid_flag (valid_flag),
    .done       (done),
    .lockup_err (lockup_err)
`ifdef PERIOD_CHECK_EN
    ,
    .period       (period),
    .period_valid (period_valid)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] model_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // One start transaction; optional hold of hold_len cycles after word number hold_at.
  task automatic run_seq(input logic [3:0] sd, input logic [7:0] cnt,
                         input int hold_at, input int hold_len);
    logic [3:0] s;
    logic [3:0] eff;
    logic [3:0] held;
    int nvalid;
    int hleft;
    bit prev_ok;
    bit got_done;
    eff = (sd == 4'b0000) ? 4'b0001 : sd;
    s = eff;
    held = '0;
    nvalid = 0;
    hleft = 0;
    got_done = 0;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      s = model_step(s);
      exp_q.push_back(s);
    end
    @(negedge clock);
    start = 1'b1; seed = sd; step_count = cnt;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    @(negedge clock);
    check("seed_loaded", data_out, eff);
    check("load_valid", valid_flag, 0);
    check("lockup_err", lockup_err, (sd == 4'b0000));
    prev_ok = 1;
    for (int c = 0; c < 2 * int'(cnt) + hold_len + 20 && !got_done; c++) begin
      @(negedge clock);
      if (c == 0) check("lockup_clear", lockup_err, 0);
      if (hleft > 0) begin
        check("hold_valid", valid_flag, 0);
        check("hold_data", data_out, held);
        hleft--;
        if (hleft == 0) hold = 1'b0;
        prev_ok = 0;
      end else if (valid_flag) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else check("word", data_out, exp_q.pop_front());
        nvalid++;
        prev_ok = 1;
        if (nvalid == hold_at && hold_len > 0) begin
          hold = 1'b1;
          hleft = hold_len;
          held = data_out;
        end
      end else if (done) begin
        check("done_follows_last", prev_ok, 1);
        check("words_left", exp_q.size(), 0);
        got_done = 1;
      end else begin
        prev_ok = 0;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    $display("run seed=%b count=%0d words=%0d done=%0d", sd, cnt, nvalid, got_done);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    bit seen;
    int nv;
    reset = 1'b1; start = 1'b0; seed = '0; step_count = '0; hold = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {valid_flag, done, lockup_err}, 0);
    reset = 1'b0;

    run_seq(4'b0001, 8'd3, 0, 0);
`ifdef PERIOD_CHECK_EN
    check("no_period", period_valid, 0);
`endif
    run_seq(4'b0110, 8'd0, 0, 0);
    run_seq(4'b0000, 8'd2, 0, 0);
    run_seq(4'b0001, 8'd5, 2, 2);
    run_seq(4'b1011, 8'd255, 0, 0);

    // Reset mid-run, with a start attempt while busy that must be ignored.
    exp_q.delete();
    begin
      logic [3:0] s;
      s = 4'b0001;
      for (int i = 0; i < 10; i++) begin s = model_step(s); exp_q.push_back(s); end
    end
    @(negedge clock);
    start = 1'b1; seed = 4'b0001; step_count = 8'd10;
    @(negedge clock);
    start = 1'b0;
    nv = 0;
    for (int c = 0; c < 20 && nv < 3; c++) begin
      @(negedge clock);
      if (valid_flag) begin
        check("pre_reset_word", data_out, exp_q.pop_front());
        nv++;
      end
    end
    check("pre_reset_words", nv, 3);
    start = 1'b1; seed = 4'b0110; step_count = 8'd2;
    @(negedge clock);
    start = 1'b0;
    check("start_ignored", data_out, exp_q.pop_front());
    #1 reset = 1'b1; start = 1'b1;
    #1;
    check("async_rst_data", data_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_flags", {valid_flag, done, lockup_err}, 0);
    @(negedge clock);
    check("reset_beats_start", busy, 0);
    start = 1'b0; reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (busy) seen = 1;
    end
    check("no_queued_start", seen, 0);
    $display("reset mid-run done");
    run_seq(4'b0001, 8'd3, 0, 0);

`ifdef PERIOD_CHECK_EN
    run_seq(4'b0001, 8'd20, 0, 0);
    check("period_valid", period_valid, 1);
    check("period", period, 15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
